// File: rtl/crc_param_gen_if.sv
// Beat/result bus between a message source and crc_param_gen.
// The expected_crc/crc_match pair exists only when CRC_CHECK_EN is defined.
interface crc_param_gen_if #(
  parameter int CRC_W  = 8,
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              last;
  logic              in_ready;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_done;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]  expected_crc;
  logic              crc_match;

  modport master (
    output data_in, data_valid, last, expected_crc,
    input  in_ready, crc_out, crc_done, crc_match
  );
  modport slave (
    input  data_in, data_valid, last, expected_crc,
    output in_ready, crc_out, crc_done, crc_match
  );
`else
  modport master (
    output data_in, data_valid, last,
    input  in_ready, crc_out, crc_done
  );
  modport slave (
    input  data_in, data_valid, last,
    output in_ready, crc_out, crc_done
  );
`endif
endinterface

// File: rtl/crc_param_gen.sv
// Parametrised CRC generator: DATA_W LFSR steps per accepted beat, held result with a done strobe.
// Define CRC_CHECK_EN to add the expected_crc comparator and the registered crc_match flag.
module crc_param_gen #(
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = 8'h49,
  parameter logic [CRC_W-1:0] INIT   = 8'h00,
  parameter logic [CRC_W-1:0] XOROUT = 8'hFF,
  parameter int               DATA_W = 1,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  crc_param_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CRC_W-1:0] crc_out_q, crc_out_d;
  logic [CRC_W-1:0] lfsr_seed, lfsr_next, lfsr_rev, final_val;
  logic             in_ready, accept;

  // Only RUN carries a partial remainder; IDLE always starts a message from INIT.
  assign lfsr_seed = (state_q == ST_RUN) ? lfsr_q : INIT;
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept    = bus.data_valid && in_ready;

  always_comb begin
    logic in_bit;
    logic fb;
    in_bit    = 1'b0;
    fb        = 1'b0;
    lfsr_next = lfsr_seed;
    for (int i = 0; i < DATA_W; i++) begin
      in_bit    = REFIN ? bus.data_in[i] : bus.data_in[DATA_W-1-i];
      fb        = lfsr_next[CRC_W-1] ^ in_bit;
      lfsr_next = {lfsr_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  for (genvar gi = 0; gi < CRC_W; gi++) begin : g_rev
    assign lfsr_rev[gi] = lfsr_next[CRC_W-1-gi];
  end

  assign final_val = (REFOUT ? lfsr_rev : lfsr_next) ^ XOROUT;

`ifdef CRC_CHECK_EN
  logic crc_match_q, crc_match_d;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    crc_out_d = crc_out_q;
`ifdef CRC_CHECK_EN
    crc_match_d = crc_match_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (state_q == ST_IDLE) begin
          lfsr_d = INIT;
        end
        if (accept) begin
          if (bus.last) begin
            state_d   = ST_DONE;
            lfsr_d    = INIT;
            crc_out_d = final_val;
`ifdef CRC_CHECK_EN
            crc_match_d = (final_val == bus.expected_crc);
`endif
          end else begin
            state_d = ST_RUN;
            lfsr_d  = lfsr_next;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        lfsr_d  = INIT;
      end
      default: begin
        state_d = ST_IDLE;
        lfsr_d  = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= INIT;
      crc_out_q <= '0;
`ifdef CRC_CHECK_EN
      crc_match_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      crc_out_q <= crc_out_d;
`ifdef CRC_CHECK_EN
      crc_match_q <= crc_match_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.crc_out  = crc_out_q;
  assign bus.crc_done = (state_q == ST_DONE);
`ifdef CRC_CHECK_EN
  assign bus.crc_match = crc_match_q;
`endif

endmodule
